// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive-side buffer.
package uart_pkg;

  typedef enum logic [1:0] {
    ARM    = 2'd0,
    SETTLE = 2'd1,
    LISTEN = 2'd2
  } rx_state_t;

  localparam int RX_DEPTH = 16;
  localparam int RX_CNT_W = 8;

  // Occupancy needs one extra bit so that a full FIFO (count == depth) is representable.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO: write visible at the head one edge later, pop takes effect at the edge.
// A write while full is refused unless a pop happens in the same cycle; a pop while empty is ignored.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  input  logic                        rd_en,
  output logic [7:0]                  rd_data,
  output logic                        empty,
  output logic                        full,
  output logic [count_w(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Pointers carry one wrap bit, so their difference is the occupancy directly.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = rd_en & ~empty;
  assign do_push = wr_en & (~full | do_pop);
  assign rd_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// Re-arms the UART receiver per frame and buffers good bytes in a FWFT FIFO; flag-to-write latency one clk.
// Host pops with rd_valid/rd_ready; a byte arriving to a full FIFO sets overflow. Error counters under RX_BUFFER_ERRCNT_EN.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_DEPTH,
  parameter int CNT_W = RX_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_enable,
  input  logic                      Rx_sample_ENABLE,
  input  logic [7:0]                Rx_DATA,
  input  logic                      Rx_VALID,
  input  logic                      Rx_PERROR,
  input  logic                      Rx_FERROR,
  output logic                      Rx_EN,
  output logic [7:0]                rd_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [count_w(DEPTH)-1:0] fifo_count,
  output logic                      overflow,
  input  logic                      overflow_clr,
  output logic [CNT_W-1:0]          perror_cnt,
  output logic [CNT_W-1:0]          ferror_cnt
);

  rx_state_t state;
  rx_state_t state_nxt;
  logic      fifo_wr;
  logic      fifo_empty;
  logic      fifo_full;
  logic      ovf_set;

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (Rx_DATA),
    .rd_en   (rd_ready),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign rd_valid = ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARM;
    else        state <= state_nxt;
  end

  // Flags seen in LISTEN are always fresh: the receiver was cleared while Rx_EN was low.
  always_comb begin
    state_nxt = state;
    Rx_EN     = 1'b0;
    fifo_wr   = 1'b0;
    ovf_set   = 1'b0;
    unique case (state)
      ARM:    if (Rx_sample_ENABLE) state_nxt = SETTLE;
      SETTLE: state_nxt = rx_enable ? LISTEN : ARM;
      LISTEN: begin
        Rx_EN = 1'b1;
        if (Rx_FERROR || Rx_PERROR) begin
          state_nxt = ARM;
        end else if (Rx_VALID) begin
          state_nxt = ARM;
          fifo_wr   = 1'b1;
          ovf_set   = fifo_full & ~rd_ready;
        end else if (!rx_enable) begin
          state_nxt = ARM;
        end
      end
      default: state_nxt = ARM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (ovf_set)      overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

`ifdef RX_BUFFER_ERRCNT_EN
  logic perr_evt;
  logic ferr_evt;

  assign ferr_evt = (state == LISTEN) & Rx_FERROR;
  assign perr_evt = (state == LISTEN) & ~Rx_FERROR & Rx_PERROR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perror_cnt <= '0;
      ferror_cnt <= '0;
    end else if (overflow_clr) begin
      perror_cnt <= '0;
      ferror_cnt <= '0;
    end else begin
      if (perr_evt && (perror_cnt != '1)) perror_cnt <= perror_cnt + 1'b1;
      if (ferr_evt && (ferror_cnt != '1)) ferror_cnt <= ferror_cnt + 1'b1;
    end
  end
`else
  assign perror_cnt = '0;
  assign ferror_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: a behavioural receiver drives frames, expected bytes queue up and are checked on pop.
module tb_uart_rx_buffer;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef RX_BUFFER_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_enable = 1'b0;
  logic             Rx_sample_ENABLE = 1'b0;
  logic [7:0]       Rx_DATA = 8'h00;
  logic             Rx_VALID = 1'b0;
  logic             Rx_PERROR = 1'b0;
  logic             Rx_FERROR = 1'b0;
  logic             Rx_EN;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [CW-1:0]    fifo_count;
  logic             overflow;
  logic             overflow_clr = 1'b0;
  logic [CNT_W-1:0] perror_cnt;
  logic [CNT_W-1:0] ferror_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  bit         ovf_m = 1'b0;
  int         pe_m = 0;
  int         fe_m = 0;

  uart_rx_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx_enable        (rx_enable),
    .Rx_sample_ENABLE (Rx_sample_ENABLE),
    .Rx_DATA          (Rx_DATA),
    .Rx_VALID         (Rx_VALID),
    .Rx_PERROR        (Rx_PERROR),
    .Rx_FERROR        (Rx_FERROR),
    .Rx_EN            (Rx_EN),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .overflow_clr     (overflow_clr),
    .perror_cnt       (perror_cnt),
    .ferror_cnt       (ferror_cnt)
  );

  always #5 clk = ~clk;

  // Sample strobe: one clk wide every 16 clk, changed on the falling edge.
  initial begin
    forever begin
      repeat (15) @(negedge clk);
      Rx_sample_ENABLE = 1'b1;
      @(negedge clk);
      Rx_SAMPLE_low();
    end
  end

  task automatic Rx_SAMPLE_low();
    Rx_sample_ENABLE = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters();
    check("perror_cnt", 32'(perror_cnt), ERRCNT ? 32'(pe_m) : 32'd0);
    check("ferror_cnt", 32'(ferror_cnt), ERRCNT ? 32'(fe_m) : 32'd0);
  endtask

  task automatic wait_listen();
    int n = 0;
    while (!Rx_EN && n < 100) begin
      tick();
      n++;
    end
    if (!Rx_EN) check("arm_timeout", 32'(Rx_EN), 32'd1);
  endtask

  // kind: bit0 VALID, bit1 PERROR, bit2 FERROR. Flags held until the DUT drops Rx_EN.
  task automatic send_frame(input logic [2:0] kind, input logic [7:0] d, input bit pop_same);
    int n = 0;
    wait_listen();
    Rx_DATA   = d;
    Rx_VALID  = kind[0];
    Rx_PERROR = kind[1];
    Rx_FERROR = kind[2];
    rd_ready  = pop_same;
    do begin
      tick();
      n++;
    end while (Rx_EN && n < 8);
    Rx_VALID  = 1'b0;
    Rx_PERROR = 1'b0;
    Rx_FERROR = 1'b0;
    rd_ready  = 1'b0;
    check("en_drop_cycles", 32'(n), 32'd1);
    if (pop_same && exp_q.size() > 0) void'(exp_q.pop_front());
    if (kind[2]) begin
      if (fe_m < 255) fe_m++;
    end else if (kind[1]) begin
      if (pe_m < 255) pe_m++;
    end else if (kind[0]) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else ovf_m = 1'b1;
    end
    check("count", 32'(fifo_count), 32'(exp_q.size()));
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("rd_valid", 32'(rd_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("head", 32'(rd_data), 32'(exp_q[0]));
  endtask

  task automatic pop_one();
    check("pop_valid", 32'(rd_valid), 32'd1);
    if (exp_q.size() > 0) check("pop_data", 32'(rd_data), 32'(exp_q[0]));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check("pop_count", 32'(fifo_count), 32'(exp_q.size()));
    if (exp_q.size() > 0) check("pop_head", 32'(rd_data), 32'(exp_q[0]));
  endtask

  initial begin
    int n;
    bit en_seen;

    repeat (3) tick();
    check("rst_rx_en", 32'(Rx_EN), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check_counters();
    rst_n = 1'b1;
    rx_enable = 1'b1;

    // Rx_EN stays low until the first strobe has been seen plus one settle cycle.
    n = 0;
    en_seen = 1'b0;
    while (!Rx_sample_ENABLE && n < 40) begin
      tick();
      n++;
      if (Rx_EN) en_seen = 1'b1;
    end
    check("arm_en_low", 32'(en_seen), 32'd0);
    check("strobe_seen", 32'(Rx_sample_ENABLE), 32'd1);
    check("settle_en", 32'(Rx_EN), 32'd0);
    tick();
    check("listen_en", 32'(Rx_EN), 32'd1);
    check("idle_valid", 32'(rd_valid), 32'd0);
    check("idle_count", 32'(fifo_count), 32'd0);

    send_frame(3'b001, 8'hA5, 1'b0);
    send_frame(3'b001, 8'h3C, 1'b0);
    check("two_count", 32'(fifo_count), 32'd2);
    check("two_head", 32'(rd_data), 32'hA5);
    pop_one();
    check("after_pop_head", 32'(rd_data), 32'h3C);
    pop_one();

    for (int i = 0; i < DEPTH; i++) send_frame(3'b001, 8'(i * 13 + 7), 1'b0);
    check("full_count", 32'(fifo_count), 32'(DEPTH));
    send_frame(3'b001, 8'h77, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(fifo_count), 32'(DEPTH));
    check("ovf_head", 32'(rd_data), 32'h07);

    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    ovf_m = 1'b0;
    pe_m = 0;
    fe_m = 0;
    check("ovf_clr", 32'(overflow), 32'd0);

    send_frame(3'b001, 8'h88, 1'b1);
    check("full_pop_write_count", 32'(fifo_count), 32'(DEPTH));
    check("full_pop_write_ovf", 32'(overflow), 32'd0);
    while (exp_q.size() > 0) pop_one();

    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("empty_pop_count", 32'(fifo_count), 32'd0);
    check("empty_pop_valid", 32'(rd_valid), 32'd0);

    send_frame(3'b010, 8'h11, 1'b0);
    check_counters();
    send_frame(3'b100, 8'h22, 1'b0);
    check_counters();
    send_frame(3'b101, 8'h33, 1'b0);
    check_counters();
    check("err_no_write", 32'(fifo_count), 32'd0);

    for (int i = 0; i < 5; i++) send_frame(3'b001, 8'(8'hC0 + i), 1'b0);
    send_frame(3'b001, 8'hEE, 1'b0);
    wait_listen();
    check("pre_rst_count", 32'(fifo_count), 32'd6);
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_en", 32'(Rx_EN), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_state", 32'(dut.state), 32'(ARM));
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    ovf_m = 1'b0;
    pe_m = 0;
    fe_m = 0;
    check_counters();

    send_frame(3'b001, 8'h5A, 1'b0);
    pop_one();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
